// File: rtl/avalon_bram_burst.sv
// Avalon-MM burst slave over one synchronous-read block RAM, with per-byte writes and address wrap.
// Define AVB_BRAM_OUTREG_EN to add a readdata/readdatavalid register stage (read latency 2 instead of 1).
module avalon_bram_burst #(
  parameter int unsigned DATA_BYTES   = 4,
  parameter int unsigned RAM_ADD_W    = 11,
  parameter int unsigned BURSTCOUNT_W = 6
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [31:0]               address,
  input  logic [DATA_BYTES-1:0]     byteenable,
  input  logic                      read,
  input  logic                      write,
  input  logic [8*DATA_BYTES-1:0]   writedata,
  input  logic [BURSTCOUNT_W-1:0]   burstcount,
  output logic [8*DATA_BYTES-1:0]   readdata,
  output logic                      readdatavalid,
  output logic                      waitrequest
);

  localparam int unsigned DW         = 8 * DATA_BYTES;
  localparam int unsigned BYTE_SEL_W = $clog2(DATA_BYTES);
  localparam int unsigned DEPTH      = 2 ** RAM_ADD_W;

  typedef enum logic [1:0] {IDLE, WRITE_BURST, READ_BURST} state_t;

  state_t                  state;
  logic [BURSTCOUNT_W-1:0] remain;
  logic [RAM_ADD_W-1:0]    next_idx;

  logic [RAM_ADD_W-1:0]    cmd_idx_c;
  logic                    multi_beat_c;
  logic                    rd_en_c;
  logic                    wr_en_c;
  logic [RAM_ADD_W-1:0]    rd_idx_c;
  logic [RAM_ADD_W-1:0]    wr_idx_c;
  logic                    unused_addr_c;

  logic [DW-1:0]           mem [DEPTH];
  logic [DW-1:0]           ram_q;
  logic                    ram_q_valid;

  assign cmd_idx_c     = address[BYTE_SEL_W +: RAM_ADD_W];
  // burstcount 0 behaves as 1, so only counts above 1 open a burst
  assign multi_beat_c  = (burstcount > BURSTCOUNT_W'(1));
  assign unused_addr_c = ^address;

  // RAM port selection for the current cycle
  always_comb begin
    rd_en_c  = 1'b0;
    wr_en_c  = 1'b0;
    rd_idx_c = cmd_idx_c;
    wr_idx_c = cmd_idx_c;
    case (state)
      IDLE: begin
        if (read)       rd_en_c = 1'b1;
        else if (write) wr_en_c = 1'b1;
      end
      WRITE_BURST: begin
        wr_en_c  = write;
        wr_idx_c = next_idx;
      end
      READ_BURST: begin
        rd_en_c  = 1'b1;
        rd_idx_c = next_idx;
      end
      default: ;
    endcase
  end

  // Burst sequencing; waitrequest is high exactly while in READ_BURST
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      remain      <= '0;
      next_idx    <= '0;
      waitrequest <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (read && multi_beat_c) begin
            state       <= READ_BURST;
            remain      <= burstcount - BURSTCOUNT_W'(1);
            next_idx    <= cmd_idx_c + RAM_ADD_W'(1);
            waitrequest <= 1'b1;
          end else if (!read && write && multi_beat_c) begin
            state    <= WRITE_BURST;
            remain   <= burstcount - BURSTCOUNT_W'(1);
            next_idx <= cmd_idx_c + RAM_ADD_W'(1);
          end
        end
        WRITE_BURST: begin
          if (write) begin
            next_idx <= next_idx + RAM_ADD_W'(1);
            remain   <= remain - BURSTCOUNT_W'(1);
            if (remain == BURSTCOUNT_W'(1)) state <= IDLE;
          end
        end
        READ_BURST: begin
          next_idx <= next_idx + RAM_ADD_W'(1);
          remain   <= remain - BURSTCOUNT_W'(1);
          if (remain == BURSTCOUNT_W'(1)) begin
            state       <= IDLE;
            waitrequest <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          waitrequest <= 1'b0;
        end
      endcase
    end
  end

  // Byte-masked RAM write; contents survive reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(DATA_BYTES); i++) begin
      if (wr_en_c && byteenable[i]) mem[wr_idx_c][8*i +: 8] <= writedata[8*i +: 8];
    end
  end

  // RAM output register with the valid bit travelling alongside
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ram_q       <= '0;
      ram_q_valid <= 1'b0;
    end else begin
      ram_q_valid <= rd_en_c;
      if (rd_en_c) ram_q <= mem[rd_idx_c];
    end
  end

`ifdef AVB_BRAM_OUTREG_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      readdata      <= '0;
      readdatavalid <= 1'b0;
    end else begin
      readdata      <= ram_q;
      readdatavalid <= ram_q_valid;
    end
  end
`else
  assign readdata      = ram_q;
  assign readdatavalid = ram_q_valid;
`endif

endmodule

// File: tb/tb_avalon_bram_burst.sv
// Directed self-checking bench for avalon_bram_burst (default parameters).
module tb_avalon_bram_burst;

`ifdef AVB_BRAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk;
  logic        reset;
  logic [31:0] address;
  logic [3:0]  byteenable;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [5:0]  burstcount;
  logic [31:0] readdata;
  logic        readdatavalid;
  logic        waitrequest;

  avalon_bram_burst dut (
    .clk           (clk),
    .reset         (reset),
    .address       (address),
    .byteenable    (byteenable),
    .read          (read),
    .write         (write),
    .writedata     (writedata),
    .burstcount    (burstcount),
    .readdata      (readdata),
    .readdatavalid (readdatavalid),
    .waitrequest   (waitrequest)
  );

  int          n_chk  = 0;
  int          n_pass = 0;
  int          cyc    = 0;
  int          wr_hi  = 0;
  int          t0;
  int          n_before;
  logic [31:0] q_data[$];
  int          q_cyc[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record returned words and stall cycles away from the active edge
  always @(negedge clk) begin
    if (readdatavalid) begin
      q_data.push_back(readdata);
      q_cyc.push_back(cyc);
    end
    if (waitrequest) wr_hi = wr_hi + 1;
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    q_data.delete();
    q_cyc.delete();
    wr_hi = 0;
  endtask

  // Write burst; address is scrambled after beat 0 since the slave must ignore it
  task automatic wr_burst(input logic [31:0] addr, input int n, input logic [31:0] first,
                          input logic [3:0] be, input int gap_after);
    for (int i = 0; i < n; i++) begin
      address    = (i == 0) ? addr : 32'hFFFF_FFF0;
      write      = 1'b1;
      writedata  = first + 32'(i);
      byteenable = be;
      burstcount = 6'(n);
      step();
      if (i == gap_after) begin
        write = 1'b0;
        step();
        step();
      end
    end
    write   = 1'b0;
    address = '0;
  endtask

  task automatic rd_go(input logic [31:0] addr, input int n);
    clear_mon();
    t0         = cyc;
    address    = addr;
    burstcount = 6'(n);
    read       = 1'b1;
    step();
    read = 1'b0;
    repeat (n + 4) step();
  endtask

  initial begin
    reset = 1'b1; address = '0; byteenable = '0; read = 1'b0;
    write = 1'b0; writedata = '0; burstcount = '0;
    #1 reset = 1'b0;

    // Reset held for three cycles
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("rst_wait%0d", i), 64'(waitrequest), 64'd0);
      check($sformatf("rst_rdv%0d", i), 64'(readdatavalid), 64'd0);
      check($sformatf("rst_rdata%0d", i), 64'(readdata), 64'd0);
    end
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("post_rst_wait", 64'(waitrequest), 64'd0);
    check("post_rst_rdv", 64'(readdatavalid), 64'd0);
    step();

    // Masked write then immediate read
    wr_burst(32'h10, 1, 32'hAABBCCDD, 4'b1111, -1);
    wr_burst(32'h10, 1, 32'h11223344, 4'b0101, -1);
    rd_go(32'h10, 1);
    check("mask_cnt", 64'(q_data.size()), 64'd1);
    check("mask_data", 64'(q_data[0]), 64'hAA22CC44);
    check("mask_lat", 64'(q_cyc[0]), 64'(t0 + LAT));
    check("mask_wait", 64'(wr_hi), 64'd0);

    // Write burst with a two-cycle gap, then read it back as one burst
    wr_burst(32'h40, 8, 32'd0, 4'b1111, 3);
    rd_go(32'h40, 8);
    check("b8_cnt", 64'(q_data.size()), 64'd8);
    check("b8_wait", 64'(wr_hi), 64'd7);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("b8_data%0d", i), 64'(q_data[i]), 64'(i));
      check($sformatf("b8_cyc%0d", i), 64'(q_cyc[i]), 64'(t0 + LAT + i));
    end

    // Wrap-around from the top word to word 0
    wr_burst(32'h1FF8, 4, 32'hA0, 4'b1111, -1);
    rd_go(32'h0, 1);
    check("wrap_w0", 64'(q_data[0]), 64'hA2);
    rd_go(32'h4, 1);
    check("wrap_w1", 64'(q_data[0]), 64'hA3);
    rd_go(32'h1FFC, 2);
    check("wrap_rd_cnt", 64'(q_data.size()), 64'd2);
    check("wrap_rd0", 64'(q_data[0]), 64'hA1);
    check("wrap_rd1", 64'(q_data[1]), 64'hA2);

    // Reset in the middle of a 16-word read
    wr_burst(32'h100, 16, 32'h500, 4'b1111, -1);
    clear_mon();
    t0 = cyc; address = 32'h100; burstcount = 6'd16; read = 1'b1;
    step();
    read = 1'b0;
    step();
    step();
    reset    = 1'b0;
    n_before = q_data.size();
    @(negedge clk);
    check("mid_rst_rdv", 64'(readdatavalid), 64'd0);
    check("mid_rst_wait", 64'(waitrequest), 64'd0);
    check("mid_rst_rdata", 64'(readdata), 64'd0);
    step();
    reset = 1'b1;
    repeat (20) step();
    check("mid_before_cnt", 64'(n_before), 64'(3 - LAT));
    check("mid_no_more", 64'(q_data.size()), 64'(n_before));
    check("mid_data0", 64'(q_data[0]), 64'h500);
    check("mid_after_wait", 64'(waitrequest), 64'd0);
    rd_go(32'h100, 2);
    check("mid_reread0", 64'(q_data[0]), 64'h500);
    check("mid_reread1", 64'(q_data[1]), 64'h501);

    // Ten back-to-back single reads, then one with burstcount 0
    clear_mon();
    t0 = cyc;
    for (int i = 0; i < 10; i++) begin
      address = 32'h40 + 32'(4 * (i % 8)); burstcount = 6'd1; read = 1'b1;
      step();
    end
    address = 32'h10; burstcount = 6'd0;
    step();
    read = 1'b0;
    repeat (8) step();
    check("b2b_cnt", 64'(q_data.size()), 64'd11);
    check("b2b_wait", 64'(wr_hi), 64'd0);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("b2b_data%0d", i), 64'(q_data[i]), 64'(i % 8));
      check($sformatf("b2b_cyc%0d", i), 64'(q_cyc[i]), 64'(t0 + LAT + i));
    end
    check("bc0_data", 64'(q_data[10]), 64'hAA22CC44);
    check("bc0_cyc", 64'(q_cyc[10]), 64'(t0 + LAT + 10));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
